lcd_timing_driver: RTL and testbench

Generates raster timing for the parallel-RGB LCD panel and pulls pixel data from the upstream image-processing display block. It exports the current pixel coordinates and active resolution one cycle ahead of the panel's data-enable window. It then drives the panel's sync, data-enable and RGB pins with the returned pixel. It is the scan-side counterpart of the display/processing pipeline: that pipeline consumes `pixel_xpos`/`pixel_ypos` and returns a registered `pixel_data` one cycle later.

---
 rtl/lcd_timing_pkg.sv | 27 ++
 rtl/lcd_timing_driver.sv | 98 +++++++++
 tb/tb_lcd_timing_driver.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Panel timing sets and pixel width shared by the LCD scan logic.
// The 800x480 set is the default; the 480x272 set suits the small panel.
package lcd_timing_pkg;

  localparam int LCD_WIDTH = 24;
  localparam int CNT_W     = 11;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  localparam int P800_H_SYNC  = 128;
  localparam int P800_H_BACK  = 88;
  localparam int P800_H_DISP  = 800;
  localparam int P800_H_FRONT = 40;
  localparam int P800_V_SYNC  = 2;
  localparam int P800_V_BACK  = 33;
  localparam int P800_V_DISP  = 480;
  localparam int P800_V_FRONT = 10;

  localparam int P480_H_SYNC  = 41;
  localparam int P480_H_BACK  = 2;
  localparam int P480_H_DISP  = 480;
  localparam int P480_H_FRONT = 2;
  localparam int P480_V_SYNC  = 10;
  localparam int P480_V_BACK  = 2;
  localparam int P480_V_DISP  = 272;
  localparam int P480_V_FRONT = 2;

endpackage

// File: rtl/lcd_timing_driver.sv
// Raster counters for a parallel-RGB panel: sync/DE generation plus
// pixel coordinate requests issued one cycle ahead of data enable.
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC  = P800_H_SYNC,
  parameter int H_BACK  = P800_H_BACK,
  parameter int H_DISP  = P800_H_DISP,
  parameter int H_FRONT = P800_H_FRONT,
  parameter int V_SYNC  = P800_V_SYNC,
  parameter int V_BACK  = P800_V_BACK,
  parameter int V_DISP  = P800_V_DISP,
  parameter int V_FRONT = P800_V_FRONT,
  parameter int WIDTH   = LCD_WIDTH
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pixel_data,
  output logic [10:0]      pixel_xpos,
  output logic [10:0]      pixel_ypos,
  output logic [10:0]      h_disp,
  output logic [10:0]      v_disp,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [WIDTH-1:0] lcd_rgb,
  output logic             lcd_bl,
  output logic             lcd_clk,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX ||
      H_SYNC + H_BACK < 2 || V_SYNC + V_BACK < 1) begin : g_bad_timing
    $error("lcd_timing_driver: timing does not fit 11-bit counters");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_END   = 11'(H_SYNC);
  localparam logic [10:0] VS_END   = 11'(V_SYNC);
  localparam logic [10:0] DE_BEG   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] DE_END   = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] REQ_BEG  = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] REQ_END  = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] X_OFS    = 11'(H_SYNC + H_BACK - 2);
  localparam logic [10:0] ACT_BEG  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] ACT_END  = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] Y_OFS    = 11'(V_SYNC + V_BACK - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        bl_q;
  logic        h_wrap;
  logic        act_line;
  logic        data_req;

  assign h_wrap = (h_cnt_q == H_LAST);

  always_comb begin
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      bl_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      bl_q    <= 1'b1;
    end
  end

  // Decode stays combinational so the request leads DE by exactly one pclk.
  assign act_line = (v_cnt_q >= ACT_BEG) && (v_cnt_q < ACT_END);
  assign data_req = act_line && (h_cnt_q >= REQ_BEG) && (h_cnt_q < REQ_END);

  assign lcd_hs      = (h_cnt_q >= HS_END);
  assign lcd_vs      = (v_cnt_q >= VS_END);
  assign lcd_de      = act_line && (h_cnt_q >= DE_BEG) && (h_cnt_q < DE_END);
  assign pixel_xpos  = data_req ? h_cnt_q - X_OFS : 11'd0;
  assign pixel_ypos  = act_line ? v_cnt_q - Y_OFS : 11'd0;
  assign h_disp      = 11'(H_DISP);
  assign v_disp      = 11'(V_DISP);
  assign lcd_rgb     = lcd_de ? pixel_data : '0;
  assign lcd_bl      = bl_q;
  assign lcd_clk     = lcd_pclk;
  assign frame_start = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver on a 15x8 raster.
// Cycle index n counts pclk cycles since the last reset release.
module tb_lcd_timing_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pdata;
  logic [10:0] xpos, ypos, hd, vd;
  logic        hs, vs, de, bl, lclk, fs;
  logic [23:0] rgb;

  int vecs = 0;
  int errs = 0;
  int n = 0;

  always #5 clk = ~clk;

  // Upstream display block: returns column index one cycle later.
  always_ff @(posedge clk) pdata <= {13'd0, xpos};

  lcd_timing_driver #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .WIDTH(24)
  ) dut (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data(pdata),
    .pixel_xpos(xpos), .pixel_ypos(ypos),
    .h_disp(hd), .v_disp(vd),
    .lcd_hs(hs), .lcd_vs(vs), .lcd_de(de),
    .lcd_rgb(rgb), .lcd_bl(bl), .lcd_clk(lclk),
    .frame_start(fs)
  );

  function automatic int hc();
    return n % 15;
  endfunction

  function automatic int vc();
    return (n / 15) % 8;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
    n++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n = 0;
  endtask

  task automatic advance_to(input int pos);
    for (int i = 0; i < 240 && (n % 120) != pos; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if ({hs, vs, de, fs, bl} !== 5'b00010) begin
      $display("FAIL reset_ctl got hs/vs/de/fs/bl=%b want 00010",
               {hs, vs, de, fs, bl});
      errs++;
    end
    vecs++;
    if (xpos !== 11'd0 || ypos !== 11'd0) begin
      $display("FAIL reset_xy got %0d/%0d want 0/0", xpos, ypos);
      errs++;
    end
    vecs++;
    if (rgb !== 24'd0) begin
      $display("FAIL reset_rgb got %0h want 0", rgb);
      errs++;
    end
    vecs++;
    if (hd !== 11'd8 || vd !== 11'd4) begin
      $display("FAIL reset_disp got %0d/%0d want 8/4", hd, vd);
      errs++;
    end
    vecs++;
    if (lclk !== clk) begin
      $display("FAIL lcd_clk got %b want %b", lclk, clk);
      errs++;
    end
  endtask

  task automatic test_sync();
    int vs_low = 0;
    int fs_cnt = 0;
    release_rst();
    for (int i = 0; i < 120; i++) begin
      if (!vs) vs_low++;
      if (fs) fs_cnt++;
      if (n < 15) begin
        vecs++;
        if (hs !== (hc() >= 2)) begin
          $display("FAIL hsync n=%0d got %b want %b", n, hs, hc() >= 2);
          errs++;
        end
      end
      if (n >= 1) begin
        vecs++;
        if (bl !== 1'b1) begin
          $display("FAIL backlight n=%0d got %b want 1", n, bl);
          errs++;
        end
      end
      step();
    end
    vecs++;
    if (vs_low != 15) begin
      $display("FAIL vsync_width got %0d want 15", vs_low);
      errs++;
    end
    vecs++;
    if (fs_cnt != 1) begin
      $display("FAIL frame_start_count got %0d want 1", fs_cnt);
      errs++;
    end
  endtask

  task automatic test_frame_start();
    for (int i = 0; i < 120; i++) begin
      vecs++;
      if (fs !== ((n % 120) == 0)) begin
        $display("FAIL frame_start n=%0d got %b want %b",
                 n, fs, (n % 120) == 0);
        errs++;
      end
      step();
    end
  endtask

  task automatic test_active_line();
    int h;
    advance_to(45);
    for (int i = 0; i < 15; i++) begin
      h = hc();
      vecs++;
      if (xpos !== ((h >= 4 && h < 12) ? 11'(h - 3) : 11'd0)) begin
        $display("FAIL xpos h=%0d got %0d want %0d", h, xpos,
                 (h >= 4 && h < 12) ? h - 3 : 0);
        errs++;
      end
      vecs++;
      if (de !== (h >= 5 && h < 13)) begin
        $display("FAIL de h=%0d got %b want %b", h, de, h >= 5 && h < 13);
        errs++;
      end
      vecs++;
      if (ypos !== 11'd1) begin
        $display("FAIL ypos h=%0d got %0d want 1", h, ypos);
        errs++;
      end
      vecs++;
      if (rgb !== ((h >= 5 && h < 13) ? 24'(h - 4) : 24'd0)) begin
        $display("FAIL rgb h=%0d got %0d want %0d", h, rgb,
                 (h >= 5 && h < 13) ? h - 4 : 0);
        errs++;
      end
      step();
    end
  endtask

  task automatic test_blanking();
    advance_to(0);
    for (int i = 0; i < 120; i++) begin
      if (vc() < 3 || vc() == 7) begin
        vecs++;
        if (xpos !== 11'd0 || ypos !== 11'd0 || de !== 1'b0
            || rgb !== 24'd0) begin
          $display("FAIL blank v=%0d h=%0d got x=%0d y=%0d de=%b rgb=%0h",
                   vc(), hc(), xpos, ypos, de, rgb);
          errs++;
        end
      end else begin
        vecs++;
        if (ypos !== 11'(vc() - 2)) begin
          $display("FAIL active_ypos v=%0d got %0d want %0d",
                   vc(), ypos, vc() - 2);
          errs++;
        end
      end
      step();
    end
  endtask

  task automatic test_wrap();
    advance_to(119);
    vecs++;
    if ({hs, vs, fs, de} !== 4'b1100) begin
      $display("FAIL pre_wrap got hs/vs/fs/de=%b want 1100", {hs, vs, fs, de});
      errs++;
    end
    step();
    vecs++;
    if ({hs, vs, fs, de} !== 4'b0010) begin
      $display("FAIL post_wrap got hs/vs/fs/de=%b want 0010", {hs, vs, fs, de});
      errs++;
    end
  endtask

  task automatic test_midframe_reset();
    int cnt = 0;
    advance_to(69);
    vecs++;
    if (xpos !== 11'd6 || ypos !== 11'd2 || de !== 1'b1) begin
      $display("FAIL pre_reset got x=%0d y=%0d de=%b want 6/2/1",
               xpos, ypos, de);
      errs++;
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({hs, vs, de, fs, bl} !== 5'b00010 || xpos !== 11'd0
        || ypos !== 11'd0 || rgb !== 24'd0) begin
      $display("FAIL async_reset got ctl=%b x=%0d y=%0d rgb=%0h want 00010/0/0/0",
               {hs, vs, de, fs, bl}, xpos, ypos, rgb);
      errs++;
    end
    repeat (3) @(negedge clk);
    release_rst();
    vecs++;
    if (fs !== 1'b1 || hs !== 1'b0) begin
      $display("FAIL restart got fs=%b hs=%b want 1/0", fs, hs);
      errs++;
    end
    while (!de && cnt < 200) begin
      step();
      cnt++;
    end
    vecs++;
    if (n != 50) begin
      $display("FAIL first_de got %0d want 50", n);
      errs++;
    end
    vecs++;
    if (rgb !== 24'd1) begin
      $display("FAIL first_rgb got %0d want 1", rgb);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_frame_start();
    test_active_line();
    test_blanking();
    test_wrap();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
